// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 8N1-style UART receiver driven by a 16x sample-tick clock enable
module uart_rx_oversampled #(
  parameter int DBIT = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);
  localparam int SMAX = OVERSAMPLE > SB_TICK ? OVERSAMPLE : SB_TICK;
  localparam int SW = $clog2(SMAX);
  localparam int NW = $clog2(DBIT) + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic [SW-1:0] s_cnt, s_cnt_n;
  logic [NW-1:0] n, n_n;
  logic [DBIT-1:0] shreg, shreg_n, dout_n;
  logic done_n, fe_n, rx_m, rx_s;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      s_cnt <= '0;
      n <= '0;
      shreg <= '0;
      dout <= '0;
      frame_err <= 1'b0;
      rx_done_tick <= 1'b0;
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      state <= state_n;
      s_cnt <= s_cnt_n;
      n <= n_n;
      shreg <= shreg_n;
      dout <= dout_n;
      frame_err <= fe_n;
      rx_done_tick <= done_n;
      rx_m <= rx;
      rx_s <= rx_m;
    end
  // A start is confirmed only if the line is still low at mid start bit
  always_comb begin
    state_n = state;
    s_cnt_n = s_cnt;
    n_n = n;
    shreg_n = shreg;
    dout_n = dout;
    fe_n = frame_err;
    done_n = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        s_cnt_n = '0;
      end
      START: if (s_tick) begin
        if (s_cnt == SW'(OVERSAMPLE/2 - 1)) begin
          state_n = rx_s ? IDLE : DATA;
          s_cnt_n = '0;
          n_n = '0;
        end else s_cnt_n = s_cnt + 1'b1;
      end
      DATA: if (s_tick) begin
        if (s_cnt == SW'(OVERSAMPLE - 1)) begin
          s_cnt_n = '0;
          shreg_n = DBIT'({rx_s, shreg} >> 1);
          state_n = (n == NW'(DBIT - 1)) ? STOP : DATA;
          n_n = (n == NW'(DBIT - 1)) ? n : n + 1'b1;
        end else s_cnt_n = s_cnt + 1'b1;
      end
      STOP: if (s_tick) begin
        if (s_cnt == SW'(SB_TICK - 1)) begin
          dout_n = shreg;
          fe_n = ~rx_s;
          done_n = 1'b1;
          state_n = rx_s ? IDLE : WAIT_HIGH;
        end else s_cnt_n = s_cnt + 1'b1;
      end
      WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
      default: state_n = IDLE;
    endcase
  end
endmodule
